rr_arbiter: RTL
===============

# rr_arbiter

Round-robin arbiter that shares one downstream resource among 2^n requesters. Priority selection is the 2^n-to-n priority-encoder function, applied to the request vector rotated by a registered priority pointer so that no requester starves. The winner's grant is held until the resource signals completion. Sits between the requesting units and the shared datapath; its `gnt_id` drives the datapath's select/mux.

## Interface
- `n`, default 3: number of grant-index bits; requester count is 2^n.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  2^n  request vector; bit i = requester i wants the resource.
- `done`  input  1  completion pulse from the current grant holder; sampled only while `busy`=1.
- `gnt`  output  2^n  one-hot grant, registered; all zeros when idle.
- `gnt_id`  output  n  binary index of the granted requester, registered.
- `busy`  output  1  high while a grant is held, registered.

## Operation
- Reset value of every output: `gnt`=0, `gnt_id`=0, `busy`=0.
- Reset value of internal state: priority pointer `ptr`=0, FSM in IDLE.
- Priority rule: search starts at index `ptr` and proceeds upward (`ptr`, `ptr`+1, …, 2^n−1, 0, …, `ptr`−1). The first set `req` bit wins.
- FSM states are IDLE and GRANT.
- IDLE, `req`=0: remain in IDLE; outputs stay zero.
- IDLE, `req`≠0: load the winner into `gnt`/`gnt_id`, set `busy`=1, go to GRANT.
- IDLE, `done`=1: ignored.
- GRANT, `done`=0: hold `gnt`/`gnt_id` unchanged. Changes on `req`, including the holder dropping its request, are ignored.
- GRANT, `done`=1: set `ptr` ← `gnt_id`+1, which wraps mod 2^n in n bits. Then arbitrate `req` against the new pointer in the same cycle.
  - Any request present: load the new winner and stay in GRANT. This gives back-to-back grants with no idle bubble.
  - No request present: clear `gnt`, `gnt_id`, and `busy`; go to IDLE.
- The finishing requester may win again only if it is the sole requester. It is lowest priority after its own completion.
- `ptr` changes only on a `done` in GRANT. A grant issued from IDLE does not move `ptr`.

## Timing
- Request-to-grant latency: 1 cycle. `req` present before edge k from IDLE → `gnt` valid after edge k.
- Done-to-next-grant latency: 1 cycle. `done` sampled at edge k → new `gnt` (or idle) after edge k.
- All outputs are driven directly from flops. The only combinational paths are `req`/`done`/`ptr` → next-state logic.
- Reset mid-grant: the next edge forces the reset values above, regardless of `req`/`done`.
- Simultaneous `reset` and `done`: reset wins.

## Structure
- Package `arb_pkg` contains:
  - `state_t` enum {IDLE, GRANT}.
  - A localparam-style function returning 2^n from n, used for the width of `req` and `gnt`.
- Sub-module `rr_prio_enc` #(n): combinational. Inputs are `req` and `ptr`. It rotates `req` right by `ptr`, priority-encodes the lowest set bit, and adds `ptr` back mod 2^n. Outputs are `idx` [n-1:0] and `valid`.
- `rr_arbiter` contains only the FSM, the `ptr` register, the output registers, and the one-hot decode of `idx` into `gnt`.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles → `gnt`=0, `gnt_id`=0, `busy`=0 throughout.
- Pointer at 0, `req`=8'b0001_0100 → next cycle `gnt`=8'b0000_0100, `gnt_id`=2, `busy`=1. Both stay unchanged for 4 cycles with `done`=0.
- Continue from the previous scenario: `done` pulse with `req` unchanged → `gnt_id`=4. A second `done` → `gnt_id`=2, because the search from `ptr`=5 wraps past 7.
- `req`=8'hFF held, `done`=1 every cycle after the first grant → `gnt_id` sequence 0,1,2,…,7,0 with `busy` continuously 1.
- `req`=8'b1000_0000 only, `ptr`=0 → `gnt_id`=7. Then `done` with `req`=0 → `busy`=0 next cycle. Next `req`=8'h01 → `gnt_id`=0, confirming `ptr` wrapped to 0.
- `reset` asserted during GRANT, with `done`=1 in the same cycle → next cycle `gnt`=0, `busy`=0. A following `req`=8'h06 grants `gnt_id`=1, confirming `ptr` was reset to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Requester count for a given grant-index width.
    function automatic int unsigned num_req(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set request at or above ptr, wrapping mod 2^n.
module rr_prio_enc
    import arb_pkg::*;
#(
    parameter int unsigned n = 3
) (
    input  logic [num_req(n)-1:0] req,
    input  logic [n-1:0]          ptr,
    output logic [n-1:0]          idx,
    output logic                  valid
);

    localparam int unsigned W = num_req(n);

    logic [W-1:0] rot;
    logic [n-1:0] off;

    // rot[i] is the request i positions above ptr; n-bit index math wraps naturally.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < W; i++) begin
            rot[i] = req[n'(i) + ptr];
        end
    end

    // Descending scan so the lowest set bit of rot is the last one written.
    always_comb begin
        off   = '0;
        valid = 1'b0;
        for (int unsigned i = W; i > 0; i--) begin
            if (rot[i-1]) begin
                off   = n'(i - 1);
                valid = 1'b1;
            end
        end
    end

    assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 2^n requesters; grant is held until the holder signals done.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned n = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [num_req(n)-1:0] req,
    input  logic                  done,
    output logic [num_req(n)-1:0] gnt,
    output logic [n-1:0]          gnt_id,
    output logic                  busy
);

    localparam int unsigned W = num_req(n);

    state_t         state, state_n;
    logic [n-1:0]   ptr, ptr_n;
    logic [n-1:0]   ptr_sel;
    logic [n-1:0]   ptr_next_holder;
    logic [n-1:0]   idx;
    logic           valid;
    logic [W-1:0]   onehot;
    logic [W-1:0]   gnt_n;
    logic [n-1:0]   gnt_id_n;
    logic           busy_n;

    assign ptr_next_holder = gnt_id + n'(1);

    // On completion the search must already use the advanced pointer this cycle.
    assign ptr_sel = (state == GRANT && done) ? ptr_next_holder : ptr;

    rr_prio_enc #(
        .n (n)
    ) u_enc (
        .req   (req),
        .ptr   (ptr_sel),
        .idx   (idx),
        .valid (valid)
    );

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        busy_n   = busy;
        case (state)
            IDLE: begin
                if (valid) begin
                    gnt_n    = onehot;
                    gnt_id_n = idx;
                    busy_n   = 1'b1;
                    state_n  = GRANT;
                end else begin
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                end
            end
            GRANT: begin
                if (done) begin
                    ptr_n = ptr_next_holder;
                    if (valid) begin
                        gnt_n    = onehot;
                        gnt_id_n = idx;
                    end else begin
                        gnt_n    = '0;
                        gnt_id_n = '0;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            busy   <= busy_n;
        end
    end

endmodule
